// File: rtl/chnl_rx_pack.sv
// Host-channel receive packer: gathers 32-bit host words into WIDTH-bit output words.
// Optional macro CHNL_RX_PACK_WCNT_EN adds the saturating accepted-word counter output wcnt.
module chnl_rx_pack #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              rx,
  output logic              rx_ack,
  input  logic              rx_last,
  input  logic [31:0]       rx_len,
  input  logic [30:0]       rx_off,
  input  logic [31:0]       rx_data,
  input  logic              rx_data_valid,
  output logic              rx_data_ren,
  output logic              o_val,
  input  logic              o_rdy,
  output logic [WIDTH-1:0]  o_data
`ifdef CHNL_RX_PACK_WCNT_EN
  ,
  output logic [31:0]       wcnt
`endif
);

  localparam int K  = WIDTH / 32;
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam logic [PW-1:0] PIECE_ZERO = PW'(0);
  localparam logic [PW-1:0] PIECE_ONE  = PW'(1);
  localparam logic [PW-1:0] PIECE_LAST = PW'(K - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    RECV  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       remaining;
  logic [PW-1:0]     piece;
  logic [WIDTH-1:0]  pack, pack_nxt;
  logic              out_free, accept, load_full, load_flush;

  // Framing fields the packer does not need.
  logic unused_fields;
  assign unused_fields = ^{rx_last, rx_off};

  assign out_free    = !o_val || o_rdy;
  assign rx_data_ren = (state == RECV) && (remaining != 32'd0) && ((piece != PIECE_LAST) || out_free);
  assign accept      = rx_data_ren && rx_data_valid;
  assign load_full   = accept && (piece == PIECE_LAST);
  assign load_flush  = (state == FLUSH) && out_free;

  // Pack register with the incoming word dropped into the current slice.
  always_comb begin
    pack_nxt = pack;
    for (int i = 0; i < K; i++) begin
      if (piece == PW'(i)) begin
        pack_nxt[32*i +: 32] = rx_data;
      end else begin
        pack_nxt[32*i +: 32] = pack[32*i +: 32];
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx) state_nxt = ACK;
        else    state_nxt = IDLE;
      end
      ACK: begin
        if (remaining == 32'd0) state_nxt = DONE;
        else                    state_nxt = RECV;
      end
      RECV: begin
        if (remaining != 32'd0)       state_nxt = RECV;
        else if (piece == PIECE_ZERO) state_nxt = DONE;
        else                          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_free) state_nxt = DONE;
        else          state_nxt = FLUSH;
      end
      DONE: begin
        if (!rx) state_nxt = IDLE;
        else     state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, pack register and output register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      remaining <= 32'd0;
      piece     <= PIECE_ZERO;
      pack      <= {WIDTH{1'b0}};
      rx_ack    <= 1'b0;
      o_val     <= 1'b0;
      o_data    <= {WIDTH{1'b0}};
    end else begin
      state  <= state_nxt;
      rx_ack <= (state_nxt == ACK);
      if ((state == IDLE) && rx) begin
        remaining <= rx_len;
        piece     <= PIECE_ZERO;
        pack      <= {WIDTH{1'b0}};
      end else if (accept) begin
        remaining <= remaining - 32'd1;
        if (piece == PIECE_LAST) begin
          piece <= PIECE_ZERO;
          pack  <= {WIDTH{1'b0}};
        end else begin
          piece <= piece + PIECE_ONE;
          pack  <= pack_nxt;
        end
      end else if (load_flush) begin
        piece <= PIECE_ZERO;
        pack  <= {WIDTH{1'b0}};
      end
      // Unfilled slices are already zero because pack clears on every load.
      if (load_full) begin
        o_val  <= 1'b1;
        o_data <= pack_nxt;
      end else if (load_flush) begin
        o_val  <= 1'b1;
        o_data <= pack;
      end else if (o_rdy) begin
        o_val  <= 1'b0;
      end
    end
  end

`ifdef CHNL_RX_PACK_WCNT_EN
  // Saturating count of accepted input words.
  always_ff @(posedge clk) begin
    if (srst) begin
      wcnt <= 32'd0;
    end else if (accept && (wcnt != 32'hFFFF_FFFF)) begin
      wcnt <= wcnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chnl_rx_pack.sv
// Bench for chnl_rx_pack: a WIDTH=64 instance driven by table and random transactions
// against a queue-based packing model, plus a WIDTH=32 instance for the backpressure case.
module tb_chnl_rx_pack;
  localparam int W = 64;
  localparam int K = W / 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         srst, rx, rx_last, rx_data_valid, o_rdy;
  logic [31:0]  rx_len, rx_data;
  logic [30:0]  rx_off;
  logic         rx_ack, rx_data_ren, o_val;
  logic [W-1:0] o_data;
  logic         b_rx, b_valid, b_o_rdy, b_ack, b_ren, b_oval;
  logic [31:0]  b_rx_len, b_rx_data, b_odata;
`ifdef CHNL_RX_PACK_WCNT_EN
  logic [31:0]  wcnt, b_wcnt;
`endif

  chnl_rx_pack #(.WIDTH(W)) dut (
    .clk(clk), .srst(srst), .rx(rx), .rx_ack(rx_ack), .rx_last(rx_last),
    .rx_len(rx_len), .rx_off(rx_off), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ren(rx_data_ren), .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data)
`ifdef CHNL_RX_PACK_WCNT_EN
    , .wcnt(wcnt)
`endif
  );

  chnl_rx_pack #(.WIDTH(32)) dut_b (
    .clk(clk), .srst(srst), .rx(b_rx), .rx_ack(b_ack), .rx_last(rx_last),
    .rx_len(b_rx_len), .rx_off(rx_off), .rx_data(b_rx_data), .rx_data_valid(b_valid),
    .rx_data_ren(b_ren), .o_val(b_oval), .o_rdy(b_o_rdy), .o_data(b_odata)
`ifdef CHNL_RX_PACK_WCNT_EN
    , .wcnt(b_wcnt)
`endif
  );

  typedef struct {
    int          len;
    logic [31:0] base;
    int          rdy;
    int          val;
    int          nout;
    logic [63:0] first;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] src_q[$];
  logic [63:0] exp_q[$];
  int ack_cnt, n_out, ren_extra, rdy_pct, val_pct, total_acc;
  logic [63:0] first_out, hold_data;
  bit hold;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock of the 64-bit channel: drive at negedge, sample the transfer due at the next posedge.
  task automatic cycle();
    @(negedge clk);
    o_rdy = ($urandom_range(0, 99) < rdy_pct);
    rx_data_valid = (src_q.size() > 0) && ($urandom_range(0, 99) < val_pct);
    rx_data = rx_data_valid ? src_q[0] : $urandom;
    #1;
    if (hold) begin
      check("hold_val", {63'd0, o_val}, 64'd1);
      check("hold_data", o_data, hold_data);
    end
    if (rx_ack) ack_cnt++;
    if (rx_data_ren && src_q.size() == 0) ren_extra++;
    if (rx_data_ren && rx_data_valid) begin
      void'(src_q.pop_front());
      total_acc++;
    end
    if (o_val && o_rdy) begin
      n_out++;
      if (n_out == 1) first_out = o_data;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out: got %h expected no output", o_data);
      end else begin
        check("out_word", o_data, exp_q.pop_front());
      end
    end
    hold = o_val && !o_rdy;
    hold_data = o_data;
  endtask

  task automatic run_txn(input int len, input logic [31:0] base, input int rdy, input int val,
                         input int nout, input bit chk_first, input logic [63:0] first);
    logic [63:0] word;
    int n;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) src_q.push_back((base != 32'd0) ? base + 32'(i) : $urandom);
    for (int i = 0; i < len; i += K) begin
      word = 64'd0;
      for (int j = 0; j < K; j++) if (i + j < len) word[32*j +: 32] = src_q[i+j];
      exp_q.push_back(word);
    end
    ack_cnt = 0; n_out = 0; ren_extra = 0; rdy_pct = rdy; val_pct = val;
    rx_len = 32'(len);
    rx = 1'b1;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || ack_cnt == 0) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL txn_timeout: got %0d words left expected 0", src_q.size() + exp_q.size());
    end
    repeat (3) cycle();
    rx = 1'b0;
    cycle();
    check("ack_count", 64'(ack_cnt), 64'd1);
    check("ren_overrun", 64'(ren_extra), 64'd0);
    check("out_count", 64'(n_out), 64'(nout));
    if (chk_first && nout > 0) check("first_out", first_out, first);
  endtask

  initial begin
    vec_t tbl[6];
    int nb, nout_b, ren_cycles, len;
    tbl[0] = '{4, 32'd1,   100, 100, 2, 64'h00000002_00000001};
    tbl[1] = '{3, 32'hA,   100, 100, 2, 64'h0000000B_0000000A};
    tbl[2] = '{0, 32'd1,   100, 100, 0, 64'h0};
    tbl[3] = '{1, 32'h11,  50,  100, 1, 64'h00000000_00000011};
    tbl[4] = '{6, 32'h20,  40,  60,  3, 64'h00000021_00000020};
    tbl[5] = '{5, 32'h30,  100, 30,  3, 64'h00000031_00000030};

    srst = 1'b1; rx = 1'b0; rx_last = 1'b0; rx_len = 32'd0; rx_off = 31'd0;
    rx_data = 32'd0; rx_data_valid = 1'b0; o_rdy = 1'b0;
    b_rx = 1'b0; b_valid = 1'b0; b_o_rdy = 1'b0; b_rx_len = 32'd0; b_rx_data = 32'd0;
    hold = 1'b0; total_acc = 0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk); #1;
    check("rst_ack", {63'd0, rx_ack}, 64'd0);
    check("rst_ren", {63'd0, rx_data_ren}, 64'd0);
    check("rst_oval", {63'd0, o_val}, 64'd0);
    check("rst_odata", o_data, 64'd0);
    check("rst_b_oval", {63'd0, b_oval}, 64'd0);

    for (int t = 0; t < 6; t++)
      run_txn(tbl[t].len, tbl[t].base, tbl[t].rdy, tbl[t].val, tbl[t].nout, 1'b1, tbl[t].first);
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, 9);
      run_txn(len, 32'd0, $urandom_range(20, 100), $urandom_range(20, 100), (len + K - 1) / K, 1'b0, 64'd0);
    end
`ifdef CHNL_RX_PACK_WCNT_EN
    check("wcnt_total", {32'd0, wcnt}, 64'(total_acc));
`endif

    // Reset after two of five words.
    nb = 0; rx_len = 32'd5; rx = 1'b1;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      @(negedge clk);
      o_rdy = 1'b1; rx_data_valid = 1'b1; rx_data = 32'h100 + 32'(nb);
      #1;
      if (rx_data_ren) nb++;
    end
    @(negedge clk);
    srst = 1'b1; rx = 1'b0; rx_data_valid = 1'b0;
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("srst_oval", {63'd0, o_val}, 64'd0);
    check("srst_odata", o_data, 64'd0);
    check("srst_ren", {63'd0, rx_data_ren}, 64'd0);
    check("srst_ack", {63'd0, rx_ack}, 64'd0);
`ifdef CHNL_RX_PACK_WCNT_EN
    check("srst_wcnt", {32'd0, wcnt}, 64'd0);
`endif
    hold = 1'b0;
    run_txn(1, 32'h77, 100, 100, 1, 1'b1, 64'h00000000_00000077);

    // WIDTH=32 backpressure: one word accepted, then stall until o_rdy rises.
    nb = 0; b_rx_len = 32'd8; b_rx = 1'b1; b_o_rdy = 1'b0; b_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_rx_data = 32'h50 + 32'(nb);
      #1;
      if (b_ren && b_valid) nb++;
    end
    check("b_stall_words", 64'(nb), 64'd1);
    check("b_stall_oval", {63'd0, b_oval}, 64'd1);
    check("b_stall_odata", {32'd0, b_odata}, 64'h50);
    nout_b = 0; ren_cycles = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      b_o_rdy = 1'b1; b_rx_data = 32'h50 + 32'(nb);
      #1;
      if (b_ren) ren_cycles++;
      if (b_ren && b_valid) nb++;
      if (b_oval && b_o_rdy) begin
        check("b_order", {32'd0, b_odata}, 64'h50 + 64'(nout_b));
        nout_b++;
      end
    end
    check("b_ren_rate", 64'(ren_cycles), 64'd7);
    check("b_words", 64'(nb), 64'd8);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    check("b_last_oval", {63'd0, b_oval}, 64'd1);
    check("b_last_odata", {32'd0, b_odata}, 64'h57);
    b_rx = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
